branch_resolve_queue: RTL and testbench

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

---
 rtl/branch_resolve_queue.sv | 92 +++++++++
 tb/tb_branch_resolve_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// In-flight branch record queue between the fetch-side predictor and execute.
// It resolves branches in order, drives predictor updates and squashes younger entries on a mispredict.
module branch_resolve_queue #(
    parameter int K     = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pred_valid,
    input  logic                       pred_taken,
    input  logic [K-1:0]               pred_index,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       res_ready,
    output logic                       update,
    output logic                       result,
    output logic [K-1:0]               up_index,
    output logic                       mispredict,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic         taken_mem [DEPTH];
    logic [K-1:0] index_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          push;
    logic          pop;
    logic          head_taken;
    logic [K-1:0]  head_index;
    logic          squash;
    logic [CW-1:0] count_nxt;

    assign pred_ready = (count != CW'(DEPTH));
    assign res_ready  = (count != '0);

    assign push       = pred_valid && pred_ready;
    assign pop        = res_valid && res_ready;
    assign head_taken = taken_mem[rd_ptr];
    assign head_index = index_mem[rd_ptr];
    assign squash     = pop && (res_taken != head_taken);

    always_comb begin
        count_nxt = count;
        if (squash)
            count_nxt = '0;
        else if (push && !pop)
            count_nxt = count + CW'(1);
        else if (pop && !push)
            count_nxt = count - CW'(1);
    end

    // Storage is not reset; a push alongside a mispredict is wrong-path and dropped.
    always_ff @(posedge clk) begin
        if (push && !squash) begin
            taken_mem[wr_ptr] <= pred_taken;
            index_mem[wr_ptr] <= pred_index;
        end
    end

    // Resolve stage boundary: outputs register one cycle after the pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            update     <= 1'b0;
            mispredict <= 1'b0;
            result     <= 1'b0;
            up_index   <= '0;
        end else begin
            update     <= pop;
            mispredict <= squash;
            count      <= count_nxt;
            if (pop) begin
                result   <= res_taken;
                up_index <= head_index;
                rd_ptr   <= rd_ptr + AW'(1);
            end
            if (squash)
                wr_ptr <= rd_ptr + AW'(1);
            else if (push)
                wr_ptr <= wr_ptr + AW'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios followed by random traffic,
// each cycle compared against a queue-based model of in-order branch resolution.
module tb_branch_resolve_queue;

    localparam int K     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pred_valid;
    logic          pred_taken;
    logic [K-1:0]  pred_index;
    logic          pred_ready;
    logic          res_valid;
    logic          res_taken;
    logic          res_ready;
    logic          update;
    logic          result;
    logic [K-1:0]  up_index;
    logic          mispredict;
    logic [CW-1:0] count;

    branch_resolve_queue #(.K(K), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_index (pred_index),
        .pred_ready (pred_ready),
        .res_valid  (res_valid),
        .res_taken  (res_taken),
        .res_ready  (res_ready),
        .update     (update),
        .result     (result),
        .up_index   (up_index),
        .mispredict (mispredict),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         taken;
        bit [K-1:0] index;
    } entry_t;

    entry_t     q[$];
    bit         exp_update;
    bit         exp_mis;
    bit         exp_result;
    bit [K-1:0] exp_index;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare all outputs after the edge.
    task automatic step(input bit rstn, input bit pv, input bit pt, input bit [K-1:0] pi,
                        input bit rv, input bit rt);
        bit do_push;
        bit do_pop;
        bit squashed;
        entry_t head;
        entry_t e;
        rst_n      = rstn;
        pred_valid = pv;
        pred_taken = pt;
        pred_index = pi;
        res_valid  = rv;
        res_taken  = rt;

        squashed = 1'b0;
        if (!rstn) begin
            q.delete();
            exp_update = 1'b0;
            exp_mis    = 1'b0;
            exp_result = 1'b0;
            exp_index  = '0;
        end else begin
            do_push = pv && (q.size() < DEPTH);
            do_pop  = rv && (q.size() > 0);
            if (do_pop) begin
                head       = q.pop_front();
                exp_update = 1'b1;
                exp_result = rt;
                exp_index  = head.index;
                exp_mis    = (rt != head.taken);
                if (exp_mis) begin
                    q.delete();
                    squashed = 1'b1;
                end
            end else begin
                exp_update = 1'b0;
                exp_mis    = 1'b0;
            end
            if (do_push && !squashed) begin
                e.taken = pt;
                e.index = pi;
                q.push_back(e);
            end
        end

        @(posedge clk);
        #1;
        chk("update",     update,     exp_update);
        chk("mispredict", mispredict, exp_mis);
        chk("result",     result,     exp_result);
        chk("up_index",   up_index,   exp_index);
        chk("count",      count,      q.size());
        chk("pred_ready", pred_ready, q.size() != DEPTH);
        chk("res_ready",  res_ready,  q.size() != 0);
    endtask

    task automatic push1(input bit pt, input bit [K-1:0] pi);
        step(1, 1, pt, pi, 0, 0);
    endtask

    task automatic pop1(input bit rt);
        step(1, 0, 0, 0, 1, rt);
    endtask

    initial begin
        bit rt;
        bit pv;
        bit rv;
        rst_n      = 1'b0;
        pred_valid = 1'b0;
        pred_taken = 1'b0;
        pred_index = '0;
        res_valid  = 1'b0;
        res_taken  = 1'b0;

        // Reset, with stimulus present that must be overridden.
        step(0, 1, 1, 4'hA, 1, 1);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Single correct resolution.
        push1(1, 4'h5);
        pop1(1);

        // Mispredict on the oldest squashes younger entries; next request ignored.
        push1(0, 4'h3);
        push1(1, 4'h7);
        push1(1, 4'h9);
        pop1(1);
        pop1(1);

        // Fill, then push-while-full plus correct pop; drain to confirm contents.
        push1(1, 4'h1);
        push1(0, 4'h2);
        push1(1, 4'h3);
        push1(0, 4'h4);
        step(1, 1, 1, 4'hE, 1, 1);
        pop1(0);
        pop1(1);
        pop1(0);
        pop1(0);

        // Pointer wrap with alternating data.
        for (int i = 0; i < 6; i++) begin
            push1(i[0], (i[0] ? 4'hA : 4'h5) ^ K'(i));
            pop1(i[0]);
        end

        // Simultaneous push and pop at count 2: correct, then mispredicted.
        push1(1, 4'h6);
        push1(0, 4'h8);
        step(1, 1, 1, 4'hB, 1, 1);
        step(1, 1, 0, 4'hC, 1, 1);
        pop1(0);

        // Reset with entries in flight and a pop requested.
        push1(1, 4'h1);
        push1(1, 4'h2);
        push1(1, 4'h3);
        step(0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0);
        pop1(1);

        // Random traffic, biased toward correct predictions so the queue fills.
        for (int i = 0; i < 400; i++) begin
            pv = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 2) == 0);
            if (q.size() > 0 && $urandom_range(0, 5) != 0)
                rt = q[0].taken;
            else
                rt = 1'($urandom);
            step(($urandom_range(0, 99) != 0), pv, 1'($urandom), K'($urandom), rv, rt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
